magia_stdout_eoc_ctrl: RTL and testbench

- Synthesizable per-tile console and end-of-computation controller for the MAGIA mesh.
- Receives one byte stream per tile, buffers each stream per tile, and arbitrates whole lines round-robin onto a single tagged byte output, so lines from different harts never interleave.
- Also captures each tile's 16-bit exit code and flags global completion.
- Sits between the tiles' stdout/EOC write decoders and the chip-level debug/console sink.

---
 rtl/magia_stdout_eoc_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_magia_stdout_eoc_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/magia_stdout_eoc_ctrl.sv
// Per-tile console buffering with line-granular round-robin output, plus
// per-tile exit-code capture and global end-of-computation flags.
module magia_stdout_eoc_ctrl #(
   parameter int N_TILES    = 4,
   parameter int FIFO_DEPTH = 64,
   parameter int HART_W     = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [N_TILES-1:0]    chr_valid_i,
   input  logic [N_TILES*8-1:0]  chr_data_i,
   output logic [N_TILES-1:0]    chr_ready_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [7:0]            out_data_o,
   output logic [HART_W-1:0]     out_hartid_o,
   output logic                  out_sol_o,
   input  logic [N_TILES-1:0]    eoc_valid_i,
   input  logic [N_TILES*16-1:0] eoc_code_i,
   output logic [N_TILES-1:0]    eoc_done_o,
   output logic [N_TILES*16-1:0] exit_code_o,
   output logic                  eoc_all_o,
   output logic                  eoc_err_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [7:0] NL = 8'h0A;

   typedef enum logic {IDLE, SEND} state_t;

   state_t                        state;
   logic [HART_W-1:0]             grant;
   logic [HART_W-1:0]             rr;
   logic                          flush;
   logic                          sol;
   logic [PW-1:0]                 byte_cnt;
   logic                          out_valid_q;

   logic [N_TILES-1:0]            full;
   logic [N_TILES-1:0]            eligible;
   logic [N_TILES-1:0][7:0]       head;
   logic [N_TILES-1:0][PW-1:0]    line_cnt;

   logic                          found;
   logic [HART_W-1:0]             next_grant;
   logic [HART_W:0]               cand_wide;

   logic [N_TILES-1:0]            done;
   logic [N_TILES*16-1:0]         codes;
   logic                          all_q;
   logic                          err_q;

   // Each tile owns a FIFO with wrap-bit pointers and a count of complete lines held
   for (genvar t = 0; t < N_TILES; t++) begin : g_tile
      logic [7:0]    mem [FIFO_DEPTH];
      logic [PW-1:0] wr_ptr;
      logic [PW-1:0] rd_ptr;
      logic [PW-1:0] lines;
      logic [7:0]    in_byte;
      logic          push;
      logic          pop;
      logic          inc;
      logic          dec;

      assign in_byte     = chr_data_i[8*t +: 8];
      assign full[t]     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      assign push        = chr_valid_i[t] && !full[t];
      assign pop         = out_valid_q && out_ready_i && (grant == HART_W'(t));
      assign head[t]     = mem[rd_ptr[AW-1:0]];
      assign inc         = push && (in_byte == NL);
      assign dec         = pop && (head[t] == NL);
      assign line_cnt[t] = lines;
      assign eligible[t] = (lines != '0) || full[t];

      always_ff @(posedge clk_i) begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_byte;
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lines  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            // A newline pushed and popped on the same cycle leaves the count unchanged
            if (inc && !dec && (lines != PW'(FIFO_DEPTH))) begin
               lines <= lines + PW'(1);
            end else if (dec && !inc) begin
               lines <= lines - PW'(1);
            end
         end
      end
   end

   assign chr_ready_o = ~full;

   // Round-robin search starting just after the last granted tile
   always_comb begin
      found      = 1'b0;
      next_grant = '0;
      cand_wide  = '0;
      for (int i = 1; i <= N_TILES; i++) begin
         cand_wide = {1'b0, rr} + (HART_W+1)'(i);
         if (cand_wide >= (HART_W+1)'(N_TILES)) begin
            cand_wide = cand_wide - (HART_W+1)'(N_TILES);
         end
         if (!found && eligible[cand_wide[HART_W-1:0]]) begin
            found      = 1'b1;
            next_grant = cand_wide[HART_W-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         grant       <= '0;
         rr          <= HART_W'(N_TILES - 1);
         flush       <= 1'b0;
         sol         <= 1'b0;
         byte_cnt    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant       <= next_grant;
                  rr          <= next_grant;
                  flush       <= (line_cnt[next_grant] == '0);
                  sol         <= 1'b1;
                  byte_cnt    <= '0;
                  out_valid_q <= 1'b1;
                  state       <= SEND;
               end
            end
            SEND: begin
               if (out_ready_i) begin
                  sol      <= 1'b0;
                  byte_cnt <= byte_cnt + PW'(1);
                  // A newline ends either mode; a flush otherwise ends after a full FIFO's worth
                  if ((head[grant] == NL) || (flush && (byte_cnt == PW'(FIFO_DEPTH - 1)))) begin
                     out_valid_q <= 1'b0;
                     state       <= IDLE;
                  end
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_valid_q ? head[grant] : 8'h00;
   assign out_hartid_o = out_valid_q ? grant : '0;
   assign out_sol_o    = out_valid_q && sol;

   // First strobe per tile wins; the summary flags trail the captures by one cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done  <= '0;
         codes <= '0;
         all_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         for (int t = 0; t < N_TILES; t++) begin
            if (eoc_valid_i[t] && !done[t]) begin
               done[t]           <= 1'b1;
               codes[16*t +: 16] <= eoc_code_i[16*t +: 16];
            end
         end
         all_q <= &done;
         err_q <= |codes;
      end
   end

   assign eoc_done_o  = done;
   assign exit_code_o = codes;
   assign eoc_all_o   = all_q;
   assign eoc_err_o   = err_q;

endmodule

// File: tb/tb_magia_stdout_eoc_ctrl.sv
// Directed bench for magia_stdout_eoc_ctrl: a vector table for the basic line
// and exit-code paths, then hand-written multi-cycle sequences.
module tb_magia_stdout_eoc_ctrl;

   localparam int N = 4;
   localparam int DEPTH = 64;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [N-1:0]  chr_valid_i;
   logic [N*8-1:0] chr_data_i;
   logic [N-1:0]  chr_ready_o;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [7:0]    out_data_o;
   logic [1:0]    out_hartid_o;
   logic          out_sol_o;
   logic [N-1:0]  eoc_valid_i;
   logic [N*16-1:0] eoc_code_i;
   logic [N-1:0]  eoc_done_o;
   logic [N*16-1:0] exit_code_o;
   logic          eoc_all_o;
   logic          eoc_err_o;

   magia_stdout_eoc_ctrl #(.N_TILES(N), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .chr_valid_i(chr_valid_i), .chr_data_i(chr_data_i), .chr_ready_o(chr_ready_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_hartid_o(out_hartid_o), .out_sol_o(out_sol_o),
      .eoc_valid_i(eoc_valid_i), .eoc_code_i(eoc_code_i), .eoc_done_o(eoc_done_o),
      .exit_code_o(exit_code_o), .eoc_all_o(eoc_all_o), .eoc_err_o(eoc_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  chr_valid;
      logic [31:0] chr_data;
      logic        out_ready;
      logic [3:0]  eoc_valid;
      logic [63:0] eoc_code;
      logic        exp_valid;
      logic [7:0]  exp_data;
      logic [1:0]  exp_hart;
      logic        exp_sol;
      logic [3:0]  exp_ready;
      logic [3:0]  exp_done;
      logic [63:0] exp_codes;
      logic        exp_all;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic [1:0] h;
      logic       s;
   } oexp_t;

   int n_compared = 0;
   int n_mismatched = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni      = 1'b0;
      chr_valid_i = '0;
      chr_data_i  = '0;
      out_ready_i = 1'b0;
      eoc_valid_i = '0;
      eoc_code_i  = '0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic push_byte(input logic [3:0] mask, input logic [7:0] b);
      chr_valid_i = mask;
      chr_data_i  = {N{b}};
      step();
      chr_valid_i = '0;
   endtask

   task automatic apply_stimulus(input vec_t v);
      chr_valid_i = v.chr_valid;
      chr_data_i  = v.chr_data;
      out_ready_i = v.out_ready;
      eoc_valid_i = v.eoc_valid;
      eoc_code_i  = v.eoc_code;
      step();
   endtask

   task automatic check_output(input int idx, input vec_t v);
      check($sformatf("row%0d valid", idx), 64'(out_valid_o), 64'(v.exp_valid));
      check($sformatf("row%0d data", idx), 64'(out_data_o), 64'(v.exp_data));
      check($sformatf("row%0d hart", idx), 64'(out_hartid_o), 64'(v.exp_hart));
      check($sformatf("row%0d sol", idx), 64'(out_sol_o), 64'(v.exp_sol));
      check($sformatf("row%0d ready", idx), 64'(chr_ready_o), 64'(v.exp_ready));
      check($sformatf("row%0d done", idx), 64'(eoc_done_o), 64'(v.exp_done));
      check($sformatf("row%0d codes", idx), exit_code_o, v.exp_codes);
      check($sformatf("row%0d all", idx), 64'(eoc_all_o), 64'(v.exp_all));
      check($sformatf("row%0d err", idx), 64'(eoc_err_o), 64'(v.exp_err));
   endtask

   task automatic check_out(input string tag, input oexp_t e);
      check({tag, " valid"}, 64'(out_valid_o), 64'(e.v));
      check({tag, " data"}, 64'(out_data_o), 64'(e.d));
      check({tag, " hart"}, 64'(out_hartid_o), 64'(e.h));
      check({tag, " sol"}, 64'(out_sol_o), 64'(e.s));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t  vecs[13];
      oexp_t seq2[8];
      oexp_t seq_rr[6];
      logic [7:0] xyz[4];
      int pushed;
      int hs;
      logic held_valid;
      logic [7:0] held_d;
      logic held_s;

      // Line from tile 1 followed by exit-code captures
      vecs[0]  = '{4'b0010, 32'h0000_6800, 1'b1, 4'h0, 64'h0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'h0, 64'h0, 1'b0, 1'b0};
      vecs[1]  = '{4'b0010, 32'h0000_6900, 1'b1, 4'h0, 64'h0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'h0, 64'h0, 1'b0, 1'b0};
      vecs[2]  = '{4'b0010, 32'h0000_0A00, 1'b1, 4'h0, 64'h0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'h0, 64'h0, 1'b0, 1'b0};
      vecs[3]  = '{4'b0000, 32'h0, 1'b1, 4'h0, 64'h0, 1'b1, 8'h68, 2'd1, 1'b1, 4'hF, 4'h0, 64'h0, 1'b0, 1'b0};
      vecs[4]  = '{4'b0000, 32'h0, 1'b1, 4'h0, 64'h0, 1'b1, 8'h69, 2'd1, 1'b0, 4'hF, 4'h0, 64'h0, 1'b0, 1'b0};
      vecs[5]  = '{4'b0000, 32'h0, 1'b1, 4'h0, 64'h0, 1'b1, 8'h0A, 2'd1, 1'b0, 4'hF, 4'h0, 64'h0, 1'b0, 1'b0};
      vecs[6]  = '{4'b0000, 32'h0, 1'b1, 4'h0, 64'h0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'h0, 64'h0, 1'b0, 1'b0};
      vecs[7]  = '{4'b0000, 32'h0, 1'b1, 4'b0001, 64'h0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'b0001, 64'h0, 1'b0, 1'b0};
      vecs[8]  = '{4'b0000, 32'h0, 1'b1, 4'b0010, 64'h0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'b0011, 64'h0, 1'b0, 1'b0};
      vecs[9]  = '{4'b0000, 32'h0, 1'b1, 4'b0100, 64'h0000_0005_0000_0000, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'b0111, 64'h0000_0005_0000_0000, 1'b0, 1'b0};
      vecs[10] = '{4'b0000, 32'h0, 1'b1, 4'b1000, 64'h0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'b1111, 64'h0000_0005_0000_0000, 1'b0, 1'b1};
      vecs[11] = '{4'b0000, 32'h0, 1'b1, 4'b0100, 64'h0000_0009_0000_0000, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'b1111, 64'h0000_0005_0000_0000, 1'b1, 1'b1};
      vecs[12] = '{4'b0000, 32'h0, 1'b1, 4'h0, 64'h0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'b1111, 64'h0000_0005_0000_0000, 1'b1, 1'b1};

      seq2[0] = '{1'b1, 8'h61, 2'd0, 1'b1};
      seq2[1] = '{1'b1, 8'h62, 2'd0, 1'b0};
      seq2[2] = '{1'b1, 8'h0A, 2'd0, 1'b0};
      seq2[3] = '{1'b0, 8'h00, 2'd0, 1'b0};
      seq2[4] = '{1'b1, 8'h61, 2'd2, 1'b1};
      seq2[5] = '{1'b1, 8'h62, 2'd2, 1'b0};
      seq2[6] = '{1'b1, 8'h0A, 2'd2, 1'b0};
      seq2[7] = '{1'b0, 8'h00, 2'd0, 1'b0};

      seq_rr[0] = '{1'b1, 8'h63, 2'd3, 1'b1};
      seq_rr[1] = '{1'b1, 8'h0A, 2'd3, 1'b0};
      seq_rr[2] = '{1'b0, 8'h00, 2'd0, 1'b0};
      seq_rr[3] = '{1'b1, 8'h63, 2'd1, 1'b1};
      seq_rr[4] = '{1'b1, 8'h0A, 2'd1, 1'b0};
      seq_rr[5] = '{1'b0, 8'h00, 2'd0, 1'b0};

      xyz[0] = 8'h78; xyz[1] = 8'h79; xyz[2] = 8'h7A; xyz[3] = 8'h0A;

      // Reset state
      do_reset();
      check_out("reset", '{1'b0, 8'h00, 2'd0, 1'b0});
      check("reset ready", 64'(chr_ready_o), 64'hF);
      check("reset done", 64'(eoc_done_o), 64'h0);
      check("reset codes", exit_code_o, 64'h0);
      check("reset all", 64'(eoc_all_o), 64'h0);
      check("reset err", 64'(eoc_err_o), 64'h0);

      for (int i = 0; i < 13; i++) begin
         apply_stimulus(vecs[i]);
         check_output(i, vecs[i]);
      end

      // Simultaneous lines on tiles 0 and 2, then 1 and 3 to expose the rr pointer
      $display("[TB] simultaneous lines");
      do_reset();
      out_ready_i = 1'b1;
      push_byte(4'b0101, 8'h61);
      push_byte(4'b0101, 8'h62);
      push_byte(4'b0101, 8'h0A);
      check("arb grant latency", 64'(out_valid_o), 64'h0);
      for (int k = 0; k < 8; k++) begin
         step();
         check_out($sformatf("arb cyc%0d", k), seq2[k]);
      end
      push_byte(4'b1010, 8'h63);
      push_byte(4'b1010, 8'h0A);
      for (int k = 0; k < 6; k++) begin
         step();
         check_out($sformatf("rr cyc%0d", k), seq_rr[k]);
      end

      // Tile 3 overflows without a newline and is flushed
      $display("[TB] flush");
      do_reset();
      pushed = 0;
      for (int c = 0; c < 80; c++) begin
         chr_valid_i = (pushed < 70) ? 4'b1000 : 4'b0000;
         chr_data_i  = {8'h20 + 8'(pushed), 24'h0};
         if (chr_valid_i[3] && chr_ready_o[3]) pushed++;
         step();
      end
      check("flush accepted before stall", 64'(pushed), 64'd64);
      check("flush ready low", 64'(chr_ready_o[3]), 64'h0);
      check_out("flush head", '{1'b1, 8'h20, 2'd3, 1'b1});
      out_ready_i = 1'b1;
      hs = 0;
      for (int c = 0; c < 300 && hs < 64; c++) begin
         chr_valid_i = (pushed < 70) ? 4'b1000 : 4'b0000;
         chr_data_i  = {8'h20 + 8'(pushed), 24'h0};
         if (out_valid_o && out_ready_i) begin
            check($sformatf("flush byte%0d", hs), 64'(out_data_o), 64'(8'h20 + 8'(hs)));
            check($sformatf("flush sol%0d", hs), 64'(out_sol_o), (hs == 0) ? 64'h1 : 64'h0);
            hs++;
         end
         if (chr_valid_i[3] && chr_ready_o[3]) pushed++;
         step();
      end
      check("flush handshakes", 64'(hs), 64'd64);
      for (int c = 0; c < 10; c++) begin
         chr_valid_i = (pushed < 70) ? 4'b1000 : 4'b0000;
         chr_data_i  = {8'h20 + 8'(pushed), 24'h0};
         if (chr_valid_i[3] && chr_ready_o[3]) pushed++;
         step();
         check($sformatf("flush residue idle%0d", c), 64'(out_valid_o), 64'h0);
      end
      chr_valid_i = '0;
      check("flush total pushed", 64'(pushed), 64'd70);
      push_byte(4'b1000, 8'h0A);
      hs = 0;
      for (int c = 0; c < 30 && hs < 7; c++) begin
         if (out_valid_o && out_ready_i) begin
            check($sformatf("residue byte%0d", hs), 64'(out_data_o), (hs == 6) ? 64'h0A : 64'(8'h60 + 8'(hs)));
            check($sformatf("residue sol%0d", hs), 64'(out_sol_o), (hs == 0) ? 64'h1 : 64'h0);
            hs++;
         end
         step();
      end
      check("residue handshakes", 64'(hs), 64'd7);

      // Back-pressure toggling every cycle
      $display("[TB] stall");
      do_reset();
      push_byte(4'b0001, 8'h78);
      push_byte(4'b0001, 8'h79);
      push_byte(4'b0001, 8'h7A);
      push_byte(4'b0001, 8'h0A);
      hs = 0;
      held_valid = 1'b0;
      held_d = 8'h00;
      held_s = 1'b0;
      for (int c = 0; c < 40; c++) begin
         out_ready_i = (c % 2 == 1);
         if (held_valid) begin
            check($sformatf("stall valid c%0d", c), 64'(out_valid_o), 64'h1);
            check($sformatf("stall data c%0d", c), 64'(out_data_o), 64'(held_d));
            check($sformatf("stall sol c%0d", c), 64'(out_sol_o), 64'(held_s));
         end
         if (out_valid_o && out_ready_i) begin
            if (hs < 4) begin
               check($sformatf("stall byte%0d", hs), 64'(out_data_o), 64'(xyz[hs]));
               check($sformatf("stall sol%0d", hs), 64'(out_sol_o), (hs == 0) ? 64'h1 : 64'h0);
            end
            hs++;
            held_valid = 1'b0;
         end else if (out_valid_o) begin
            held_d = out_data_o;
            held_s = out_sol_o;
            held_valid = 1'b1;
         end
         step();
      end
      check("stall handshakes", 64'(hs), 64'd4);

      // Reset in the middle of a line
      $display("[TB] reset mid-line");
      do_reset();
      push_byte(4'b0100, 8'h7A);
      push_byte(4'b0100, 8'h7A);
      push_byte(4'b0010, 8'h68);
      push_byte(4'b0010, 8'h65);
      push_byte(4'b0010, 8'h6C);
      push_byte(4'b0010, 8'h6C);
      push_byte(4'b0010, 8'h6F);
      push_byte(4'b0010, 8'h0A);
      out_ready_i = 1'b1;
      hs = 0;
      for (int c = 0; c < 20 && hs < 2; c++) begin
         if (out_valid_o && out_ready_i) hs++;
         step();
      end
      check("pre-reset handshakes", 64'(hs), 64'd2);
      check("pre-reset valid", 64'(out_valid_o), 64'h1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("async reset valid", 64'(out_valid_o), 64'h0);
      check("async reset ready", 64'(chr_ready_o), 64'hF);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         check($sformatf("post-reset idle%0d", c), 64'(out_valid_o), 64'h0);
      end
      check("post-reset ready", 64'(chr_ready_o), 64'hF);
      push_byte(4'b0001, 8'h6B);
      push_byte(4'b0001, 8'h0A);
      step();
      check_out("post-reset line", '{1'b1, 8'h6B, 2'd0, 1'b1});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
